// File: rtl/sram_icb_arbiter_pkg.sv
// Shared definitions for the two-master SRAM ICB arbiter: master IDs,
// default outstanding depth and ICB bus widths.
package sram_icb_arbiter_pkg;

   // Core register width; the ICB data bus follows it.
   localparam int XLEN      = 32;
   localparam int SRAM_AW   = 19;          // 128K x 32 byte address
   localparam int SRAM_DW   = XLEN;
   localparam int SRAM_MW   = XLEN / 8;
   localparam int DEF_OSTD  = 2;

   // Master identifiers as stored in the ID FIFO.
   typedef enum logic {
      SRAM_ARB_M0 = 1'b0,
      SRAM_ARB_M1 = 1'b1
   } arb_id_e;

   // Round-robin choice when both masters contend: the one not served last.
   function automatic logic rr_pick(input logic last_grant);
      return (last_grant == SRAM_ARB_M0) ? SRAM_ARB_M1 : SRAM_ARB_M0;
   endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// Flop-based FIFO of 1-bit master IDs, one entry per outstanding SRAM
// command. Head is the ID of the oldest command, i.e. the owner of the next
// in-order response.
module sram_arb_id_fifo #(
   parameter int OSTD = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic push_id,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;
   localparam int CW = $clog2(OSTD + 1);

   logic [OSTD-1:0] mem;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_push;
   logic            do_pop;

   // Pointers wrap modulo OSTD, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(OSTD - 1)) return '0;
      else                    return p + 1'b1;
   endfunction

   assign full    = (count == CW'(OSTD));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage, pointers and occupancy; push and pop together leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_id;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_icb_arbiter.sv
// Two-master ICB arbiter in front of the on-chip SRAM. Commands are granted
// round-robin with zero added latency; a stalled command locks the grant so
// the slave-side payload stays stable. Responses come back in order and are
// steered to the issuing master using the ID FIFO.
module sram_icb_arbiter
   import sram_icb_arbiter_pkg::*;
#(
   parameter int AW   = SRAM_AW,
   parameter int DW   = SRAM_DW,
   parameter int MW   = SRAM_MW,
   parameter int OSTD = DEF_OSTD
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_icb_cmd_valid,
   output logic          m0_icb_cmd_ready,
   input  logic [AW-1:0] m0_icb_cmd_addr,
   input  logic          m0_icb_cmd_read,
   input  logic [DW-1:0] m0_icb_cmd_wdata,
   input  logic [MW-1:0] m0_icb_cmd_wmask,
   output logic          m0_icb_rsp_valid,
   input  logic          m0_icb_rsp_ready,
   output logic [DW-1:0] m0_icb_rsp_rdata,

   input  logic          m1_icb_cmd_valid,
   output logic          m1_icb_cmd_ready,
   input  logic [AW-1:0] m1_icb_cmd_addr,
   input  logic          m1_icb_cmd_read,
   input  logic [DW-1:0] m1_icb_cmd_wdata,
   input  logic [MW-1:0] m1_icb_cmd_wmask,
   output logic          m1_icb_rsp_valid,
   input  logic          m1_icb_rsp_ready,
   output logic [DW-1:0] m1_icb_rsp_rdata,

   output logic          s_icb_cmd_valid,
   input  logic          s_icb_cmd_ready,
   output logic [AW-1:0] s_icb_cmd_addr,
   output logic          s_icb_cmd_read,
   output logic [DW-1:0] s_icb_cmd_wdata,
   output logic [MW-1:0] s_icb_cmd_wmask,
   input  logic          s_icb_rsp_valid,
   output logic          s_icb_rsp_ready,
   input  logic [DW-1:0] s_icb_rsp_rdata,

   output logic          arb_err
);

   logic grant;
   logic gnt_valid;
   logic lock;
   logic lock_id;
   logic last_grant;
   logic cmd_hs;
   logic rsp_hs;
   logic fifo_full;
   logic fifo_empty;
   logic fifo_head;

   // Grant selection: a locked master keeps the bus, otherwise a lone
   // requester wins and contention goes to the master not served last.
   always_comb begin
      grant = rr_pick(last_grant);
      if (lock) begin
         grant = lock_id;
      end else if (m0_icb_cmd_valid && !m1_icb_cmd_valid) begin
         grant = SRAM_ARB_M0;
      end else if (m1_icb_cmd_valid && !m0_icb_cmd_valid) begin
         grant = SRAM_ARB_M1;
      end
   end

   // Command mux toward the SRAM; a full FIFO blocks issue with no bypass.
   always_comb begin
      if (grant == SRAM_ARB_M1) begin
         gnt_valid       = m1_icb_cmd_valid;
         s_icb_cmd_addr  = m1_icb_cmd_addr;
         s_icb_cmd_read  = m1_icb_cmd_read;
         s_icb_cmd_wdata = m1_icb_cmd_wdata;
         s_icb_cmd_wmask = m1_icb_cmd_wmask;
      end else begin
         gnt_valid       = m0_icb_cmd_valid;
         s_icb_cmd_addr  = m0_icb_cmd_addr;
         s_icb_cmd_read  = m0_icb_cmd_read;
         s_icb_cmd_wdata = m0_icb_cmd_wdata;
         s_icb_cmd_wmask = m0_icb_cmd_wmask;
      end
   end

   assign s_icb_cmd_valid  = gnt_valid && !fifo_full;
   assign cmd_hs           = s_icb_cmd_valid && s_icb_cmd_ready;
   assign m0_icb_cmd_ready = cmd_hs && (grant == SRAM_ARB_M0);
   assign m1_icb_cmd_ready = cmd_hs && (grant == SRAM_ARB_M1);

   // Response demux: only the head-of-FIFO master sees valid; an empty FIFO
   // drains whatever the SRAM presents.
   always_comb begin
      m0_icb_rsp_valid = 1'b0;
      m1_icb_rsp_valid = 1'b0;
      s_icb_rsp_ready  = s_icb_rsp_valid;
      if (!fifo_empty) begin
         if (fifo_head == SRAM_ARB_M1) begin
            m1_icb_rsp_valid = s_icb_rsp_valid;
            s_icb_rsp_ready  = m1_icb_rsp_ready;
         end else begin
            m0_icb_rsp_valid = s_icb_rsp_valid;
            s_icb_rsp_ready  = m0_icb_rsp_ready;
         end
      end
   end

   assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
   assign rsp_hs           = s_icb_rsp_valid && s_icb_rsp_ready && !fifo_empty;

   // Lock holds a stalled grant until its handshake; last_grant drives round-robin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock       <= 1'b0;
         lock_id    <= SRAM_ARB_M0;
         last_grant <= SRAM_ARB_M1;
      end else begin
         if (cmd_hs) begin
            lock       <= 1'b0;
            last_grant <= grant;
         end else if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
            lock    <= 1'b1;
            lock_id <= grant;
         end
      end
   end

   // Sticky flag for a response that arrived with nothing outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arb_err <= 1'b0;
      end else if (s_icb_rsp_valid && fifo_empty) begin
         arb_err <= 1'b1;
      end
   end

   sram_arb_id_fifo #(
      .OSTD (OSTD)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (cmd_hs),
      .push_id (grant),
      .pop     (rsp_hs),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

endmodule
